// File: rtl/n1_ups.sv
// Upper parameter stack: four 16-bit cells with command handshake, ALU write-back,
// and spill/fill traffic to a lower stack when the cached window is too full or too shallow.
module n1_ups (
  input  logic        clk_i,
  input  logic        async_rst_i,
  input  logic        fc2ups_req_i,
  output logic        ups2fc_ack_o,
  input  logic [2:0]  fc2ups_cmd_i,
  input  logic [15:0] fc2ups_lit_i,
  input  logic        fc2ups_clr_i,
  input  logic [15:0] alu2prs_ps0_next_i,
  input  logic [15:0] alu2prs_ps1_next_i,
  output logic [15:0] prs2alu_ps0_o,
  output logic [15:0] prs2alu_ps1_o,
  output logic        ups2ls_push_req_o,
  output logic        ups2ls_pop_req_o,
  output logic [15:0] ups2ls_data_o,
  input  logic [15:0] ls2ups_data_i,
  input  logic        ls2ups_ack_i,
  input  logic        ls2ups_empty_i,
  input  logic        ls2ups_full_i,
  output logic [2:0]  ups_depth_o,
  output logic        ups_uf_o,
  output logic        ups_of_o
);

  typedef enum logic [1:0] {IDLE, SPILL, FILL} state_e;

  localparam logic [2:0] CMD_ALU  = 3'd1;
  localparam logic [2:0] CMD_PUSH = 3'd2;
  localparam logic [2:0] CMD_DROP = 3'd3;
  localparam logic [2:0] CMD_SWAP = 3'd4;

  state_e      state_q, state_d;
  logic [15:0] ps_q [4];
  logic [15:0] ps_d [4];
  logic [2:0]  depth_q, depth_d;
  logic        uf_q, uf_d, of_q, of_d;

  logic cmd_ok, too_shallow, too_deep, fire;

  // Decode whether the current command can run on the cached window as-is.
  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    cmd_ok      = 1'b1;
    too_shallow = 1'b0;
    too_deep    = 1'b0;
    case (fc2ups_cmd_i)
      CMD_ALU, CMD_SWAP: begin
        cmd_ok      = (depth_q >= 3'd2);
        too_shallow = !cmd_ok;
      end
      CMD_DROP: begin
        cmd_ok      = (depth_q >= 3'd1);
        too_shallow = !cmd_ok;
      end
      CMD_PUSH: begin
        cmd_ok   = (depth_q <= 3'd3);
        too_deep = !cmd_ok;
      end
      default: ;
    endcase
    // Errors against an empty/full lower stack still complete the handshake.
    fire = (state_q == IDLE) && fc2ups_req_i &&
           (cmd_ok || (too_shallow && ls2ups_empty_i) || (too_deep && ls2ups_full_i));
  end

  always_comb begin
    state_d = state_q;
    ps_d    = ps_q;
    depth_d = depth_q;
    uf_d    = uf_q && !fc2ups_clr_i;
    of_d    = of_q && !fc2ups_clr_i;
    case (state_q)
      IDLE: begin
        if (fire && cmd_ok) begin
          case (fc2ups_cmd_i)
            CMD_ALU: begin
              ps_d[0] = alu2prs_ps0_next_i;
              ps_d[1] = alu2prs_ps1_next_i;
            end
            CMD_PUSH: begin
              ps_d[3] = ps_q[2];
              ps_d[2] = ps_q[1];
              ps_d[1] = ps_q[0];
              ps_d[0] = fc2ups_lit_i;
              depth_d = depth_q + 3'd1;
            end
            CMD_DROP: begin
              ps_d[0] = ps_q[1];
              ps_d[1] = ps_q[2];
              ps_d[2] = ps_q[3];
              ps_d[3] = 16'h0000;
              depth_d = depth_q - 3'd1;
            end
            CMD_SWAP: begin
              ps_d[0] = ps_q[1];
              ps_d[1] = ps_q[0];
            end
            default: ;
          endcase
        end else if (fire) begin
          uf_d = uf_d || too_shallow;
          of_d = of_d || too_deep;
        end else if (fc2ups_req_i) begin
          state_d = too_deep ? SPILL : FILL;
        end
      end
      SPILL: begin
        if (ls2ups_ack_i) begin
          ps_d[3] = 16'h0000;
          depth_d = depth_q - 3'd1;
          state_d = IDLE;
        end
      end
      FILL: begin
        // Fill lands below the valid entries; depth is at most 1 here.
        if (ls2ups_ack_i) begin
          ps_d[depth_q[1:0]] = ls2ups_data_i;
          depth_d = depth_q + 3'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      state_q <= IDLE;
      ps_q    <= '{default: 16'h0000};
      depth_q <= 3'd0;
      uf_q    <= 1'b0;
      of_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ps_q    <= ps_d;
      depth_q <= depth_d;
      uf_q    <= uf_d;
      of_q    <= of_d;
    end
  end

  assign ups2fc_ack_o      = fire;
  assign prs2alu_ps0_o     = ps_q[0];
  assign prs2alu_ps1_o     = ps_q[1];
  assign ups2ls_push_req_o = (state_q == SPILL);
  assign ups2ls_pop_req_o  = (state_q == FILL);
  assign ups2ls_data_o     = ps_q[3];
  assign ups_depth_o       = depth_q;
  assign ups_uf_o          = uf_q;
  assign ups_of_o          = of_q;

endmodule

// File: tb/tb_n1_ups.sv
// Directed self-checking bench for n1_ups: handshake, stack ops, spill/fill,
// sticky error flags and asynchronous reset.
module tb_n1_ups;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, ack, clr;
  logic [2:0]  cmd;
  logic [15:0] lit, ps0n, ps1n, ps0, ps1, ls_dout, ls_din;
  logic        push_req, pop_req, ls_ack, ls_empty, ls_full, uf, of;
  logic [2:0]  depth;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [2:0] NOP = 3'd0, ALU = 3'd1, PUSH = 3'd2, DROP = 3'd3, SWAP = 3'd4;

  n1_ups dut (
    .clk_i              (clk),
    .async_rst_i        (rst),
    .fc2ups_req_i       (req),
    .ups2fc_ack_o       (ack),
    .fc2ups_cmd_i       (cmd),
    .fc2ups_lit_i       (lit),
    .fc2ups_clr_i       (clr),
    .alu2prs_ps0_next_i (ps0n),
    .alu2prs_ps1_next_i (ps1n),
    .prs2alu_ps0_o      (ps0),
    .prs2alu_ps1_o      (ps1),
    .ups2ls_push_req_o  (push_req),
    .ups2ls_pop_req_o   (pop_req),
    .ups2ls_data_o      (ls_dout),
    .ls2ups_data_i      (ls_din),
    .ls2ups_ack_i       (ls_ack),
    .ls2ups_empty_i     (ls_empty),
    .ls2ups_full_i      (ls_full),
    .ups_depth_o        (depth),
    .ups_uf_o           (uf),
    .ups_of_o           (of)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  // Present a command mid-cycle so combinational ack can be sampled before the edge.
  task automatic present(input logic [2:0] c, input logic [15:0] l);
    @(negedge clk);
    req = 1'b1; cmd = c; lit = l;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(input string tag, input logic [2:0] c, input logic [15:0] l,
                         input logic exp_ack);
    present(c, l);
    check({tag, "_ack"}, {15'd0, ack}, {15'd0, exp_ack});
    tick();
    req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; clr = 1'b0; cmd = NOP; lit = '0; ps0n = '0; ps1n = '0;
    ls_din = '0; ls_ack = 1'b0; ls_empty = 1'b0; ls_full = 1'b0;
    #3;
    check("rst_depth", {13'd0, depth}, 16'd0);
    check("rst_ack",   {15'd0, ack}, 16'd0);
    check("rst_push",  {15'd0, push_req}, 16'd0);
    check("rst_pop",   {15'd0, pop_req}, 16'd0);
    check("rst_ps0",   ps0, 16'h0000);
    check("rst_flags", {14'd0, uf, of}, 16'd0);
    #9 rst = 1'b0;

    // Spurious lower-stack ack in IDLE is ignored.
    @(negedge clk); ls_ack = 1'b1;
    tick(); ls_ack = 1'b0;
    check("spur_depth", {13'd0, depth}, 16'd0);
    check("spur_reqs",  {14'd0, push_req, pop_req}, 16'd0);

    // Two pushes, then ALU write-back.
    run_cmd("push1", PUSH, 16'h1111, 1'b1);
    run_cmd("push2", PUSH, 16'h2222, 1'b1);
    check("push_ps0",   ps0, 16'h2222);
    check("push_ps1",   ps1, 16'h1111);
    check("push_depth", {13'd0, depth}, 16'd2);
    ps0n = 16'hAAAA; ps1n = 16'h5555;
    run_cmd("alu", ALU, 16'h0000, 1'b1);
    check("alu_ps0",   ps0, 16'hAAAA);
    check("alu_ps1",   ps1, 16'h5555);
    check("alu_depth", {13'd0, depth}, 16'd2);

    run_cmd("nop", 3'd6, 16'h0000, 1'b1);
    check("nop_ps0", ps0, 16'hAAAA);

    run_cmd("drop1", DROP, 16'h0000, 1'b1);
    check("drop1_ps0",   ps0, 16'h5555);
    check("drop1_depth", {13'd0, depth}, 16'd1);
    run_cmd("drop2", DROP, 16'h0000, 1'b1);
    check("drop2_ps0",   ps0, 16'h0000);
    check("drop2_depth", {13'd0, depth}, 16'd0);

    // Fill to depth 4 with PS3 = 0x0001.
    for (int i = 1; i <= 4; i++) run_cmd("fill4", PUSH, 16'(i), 1'b1);
    check("d4_depth", {13'd0, depth}, 16'd4);
    check("d4_ps0",   ps0, 16'h0004);
    check("d4_data",  ls_dout, 16'h0001);

    // Push at depth 4 with lower stack not full: spill first.
    present(PUSH, 16'h0005);
    check("spill_ack0", {15'd0, ack}, 16'd0);
    tick();
    check("spill_req",  {14'd0, push_req, pop_req}, 16'b10);
    check("spill_data", ls_dout, 16'h0001);
    tick();
    check("spill_hold", {15'd0, push_req}, 16'd1);
    check("spill_nack", {15'd0, ack}, 16'd0);
    @(negedge clk); ls_ack = 1'b1;
    tick(); ls_ack = 1'b0;
    check("spill_done",  {15'd0, push_req}, 16'd0);
    check("spill_depth", {13'd0, depth}, 16'd3);
    check("spill_ack1",  {15'd0, ack}, 16'd1);
    tick(); req = 1'b0;
    check("spill_ps0",   ps0, 16'h0005);
    check("spill_ps1",   ps1, 16'h0004);
    check("spill_d4",    {13'd0, depth}, 16'd4);

    // Overflow against a full lower stack, then clear.
    ls_full = 1'b1;
    run_cmd("ovf", PUSH, 16'h0009, 1'b1);
    ls_full = 1'b0;
    check("ovf_flag",  {15'd0, of}, 16'd1);
    check("ovf_ps0",   ps0, 16'h0005);
    check("ovf_depth", {13'd0, depth}, 16'd4);
    @(negedge clk); clr = 1'b1;
    tick(); clr = 1'b0;
    check("ovf_clr", {15'd0, of}, 16'd0);

    // Reset in the middle of a spill.
    present(PUSH, 16'h0006);
    tick();
    check("abort_pre", {15'd0, push_req}, 16'd1);
    #2; req = 1'b0; rst = 1'b1;
    #1;
    check("abort_push",  {15'd0, push_req}, 16'd0);
    check("abort_depth", {13'd0, depth}, 16'd0);
    check("abort_ps0",   ps0, 16'h0000);
    @(negedge clk); rst = 1'b0;
    tick();
    check("abort_idle", {14'd0, push_req, pop_req}, 16'd0);

    // DROP at depth 0 with data below: fill, then drop.
    ls_din = 16'h00BE;
    present(DROP, 16'h0000);
    check("fill_ack0", {15'd0, ack}, 16'd0);
    tick();
    check("fill_req", {14'd0, push_req, pop_req}, 16'b01);
    tick();
    check("fill_hold", {15'd0, pop_req}, 16'd1);
    @(negedge clk); ls_ack = 1'b1;
    tick(); ls_ack = 1'b0;
    check("fill_ps0",   ps0, 16'h00BE);
    check("fill_depth", {13'd0, depth}, 16'd1);
    check("fill_ack1",  {15'd0, ack}, 16'd1);
    tick(); req = 1'b0;
    check("fill_final", {13'd0, depth}, 16'd0);
    check("fill_pop0",  {15'd0, pop_req}, 16'd0);

    // Underflow against an empty lower stack; clear racing a new error keeps it set.
    run_cmd("p77", PUSH, 16'h0077, 1'b1);
    ls_empty = 1'b1;
    run_cmd("uf", SWAP, 16'h0000, 1'b1);
    check("uf_flag",  {15'd0, uf}, 16'd1);
    check("uf_ps0",   ps0, 16'h0077);
    check("uf_depth", {13'd0, depth}, 16'd1);
    @(negedge clk); clr = 1'b1;
    tick(); clr = 1'b0;
    check("uf_clr", {15'd0, uf}, 16'd0);
    clr = 1'b1;
    run_cmd("uf_race", ALU, 16'h0000, 1'b1);
    clr = 1'b0;
    check("uf_race_flag", {15'd0, uf}, 16'd1);
    @(negedge clk); clr = 1'b1;
    tick(); clr = 1'b0;
    check("uf_clr2", {15'd0, uf}, 16'd0);
    ls_empty = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/n1_ups.md
N1_UPS -- requirements
Module: N1_ups

Interface
REQ-001 Parameters: none; 16-bit cells, 4-entry upper parameter stack.
REQ-002 clk_i  in  1  module clock; one clock, all state updates on its rising edge.
REQ-003 async_rst_i  in  1  reset, asynchronous, active-high.
REQ-004 fc2ups_req_i / ups2fc_ack_o  in/out  1/1  command request / acknowledge; a command transfers in any cycle with req&ack both high.
REQ-005 fc2ups_cmd_i  in  3  0 NOP, 1 ALU, 2 PUSH, 3 DROP, 4 SWAP, 5-7 treated as NOP.
REQ-006 fc2ups_lit_i  in  16  literal for PUSH.
REQ-007 fc2ups_clr_i  in  1  clears sticky error flags.
REQ-008 alu2prs_ps0_next_i / alu2prs_ps1_next_i  in  16/16  ALU results for new PS0/PS1.
REQ-009 prs2alu_ps0_o / prs2alu_ps1_o  out  16/16  current PS0/PS1, driven directly from registers.
REQ-010 ups2ls_push_req_o / ups2ls_pop_req_o  out  1/1  lower-stack spill / fill requests.
REQ-011 ups2ls_data_o  out  16  spill data (PS3); ls2ups_data_i  in  16  fill data.
REQ-012 ls2ups_ack_i / ls2ups_empty_i / ls2ups_full_i  in  1/1/1  lower-stack acknowledge and status.
REQ-013 ups_depth_o  out  3  valid entries, 0..4; ups_uf_o / ups_of_o  out  1/1  sticky underflow / overflow.

Function
REQ-014 State: PS0..PS3, depth counter, FSM {IDLE, SPILL, FILL}; invalid entries hold 0.
REQ-015 Requirements per command: ALU, SWAP depth>=2; DROP depth>=1; PUSH depth<=3; NOP none.
REQ-016 In IDLE with req high and requirement met: ack high same cycle (combinational); effect visible on outputs after the next edge.
REQ-017 ALU: PS0<=ps0_next, PS1<=ps1_next, depth unchanged.
REQ-018 PUSH: PSn<=PSn-1, PS0<=lit, depth+1; DROP: PSn-1<=PSn, PS3<=0, depth-1; SWAP: exchange PS0/PS1.
REQ-019 Too-shallow command with ls2ups_empty_i low: ack low, go to FILL.
REQ-020 PUSH with depth 4 and ls2ups_full_i low: ack low, go to SPILL.
REQ-021 FILL: pop_req high and stable until ls2ups_ack_i; on ack PS[depth]<=ls2ups_data_i, depth+1, return IDLE; command then re-evaluated.
REQ-022 SPILL: push_req high, ups2ls_data_o=PS3, stable until ack; on ack PS3<=0, depth-1, return IDLE.
REQ-023 Too-shallow command with ls2ups_empty_i high: ack high, stack unchanged, ups_uf_o set.
REQ-024 PUSH at depth 4 with ls2ups_full_i high: ack high, stack unchanged, ups_of_o set.
REQ-025 Flags stay set until fc2ups_clr_i; clr and new error same cycle: flag set.
REQ-026 ls2ups_ack_i without an outstanding request: ignored; push_req and pop_req never both high.
REQ-027 ack low in SPILL and FILL; req low in IDLE: no state change.

Reset
REQ-028 async_rst_i high: immediately PS0..PS3=0, depth 0, IDLE, ack/push_req/pop_req/flags 0, all data outputs 0.
REQ-029 Reset during SPILL/FILL aborts the transfer; requests drop without waiting for ack; lower-stack contents unchanged.

Verification
REQ-030 Reset; PUSH 0x1111, 0x2222 -> ack each cycle; then ps0_o=0x2222, ps1_o=0x1111, depth 2.
REQ-031 Depth 2, ALU with next 0xAAAA/0x5555 -> ps0_o=0xAAAA, ps1_o=0x5555 one cycle later, depth 2.
REQ-032 Depth 4 (PS3=0x0001), PUSH 0x0005, full=0 -> push_req with data 0x0001, ack after lower ack, then ps0_o=0x0005, depth 4.
REQ-033 Depth 0, DROP, empty=0, lower data 0x00BE -> pop_req, fill PS0=0x00BE, depth 0 afterwards, ack.
REQ-034 Depth 1, SWAP, empty=1 -> ack in same cycle, ups_uf_o=1, stack unchanged; clr -> ups_uf_o=0.
REQ-035 Reset asserted mid-SPILL -> push_req low immediately, depth 0, FSM IDLE.
